crc16_frame_checker: RTL
========================

// Module: crc16_frame_checker
// PURPOSE
//   Receive-side CRC-16 checker for bq79606 UART response frames. Sits between UART RX byte deframer and
//   register-response parser: tracks frame length from byte 0, runs CRC-16 (poly 0x8005 reflected/0xA001,
//   init 0xFFFF, LSB-first, no final XOR) over all bytes incl. trailing CRC (LSB byte first), flags pass/fail
//   via zero residue, forwards payload bytes, aborts on timeout/restart/bad frame type.
// PARAMETERS
//   LEN_OFFSET   5     pre-CRC byte count = byte0[6:0] + LEN_OFFSET (len + dev + 2 reg addr + N-1 adj); 1..126
//   TIMEOUT_CYC  1000  max idle sclk cycles between bytes inside a frame; 1..65535
// PORTS
//   sclk         in   1   clock
//   reset_n      in   1   async active-low reset
//   rx_data      in   8   received byte
//   rx_valid     in   1   rx_data valid, one cycle per byte
//   sof          in   1   start of frame; qualified only with rx_valid; ignored alone
//   err_clr      in   1   clears err_cnt
//   pay_data     out  8   forwarded pre-CRC byte (registered)
//   pay_valid    out  1   pay_data strobe
//   frame_done   out  1   1-cycle pulse: frame fully received
//   crc_ok       out  1   1-cycle pulse with frame_done when residue == 0
//   crc_err      out  1   1-cycle pulse with frame_done when residue != 0
//   calc_crc     out  16  CRC over pre-CRC bytes; held until next accepted sof
//   rx_crc       out  16  received CRC {hi,lo}; held until next accepted sof
//   frame_abort  out  1   1-cycle pulse: frame dropped
//   abort_code   out  2   01 timeout, 10 restarted by sof, 11 byte0[7]=1; held until next abort
//   err_cnt      out  8   saturating count of crc_err + frame_abort events
//   busy         out  1   high in any state except IDLE
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; CRC reg 0xFFFF; byte/timeout counters 0.
//   FSM: IDLE -> BODY -> CRC_LO -> CRC_HI -> IDLE.
//   IDLE: rx_valid&sof -> byte0[7]=0: CRC reg := next(0xFFFF, byte), total := byte0[6:0]+LEN_OFFSET (8 bit),
//     cnt := 1, clear calc_crc/rx_crc, forward byte; BODY (CRC_LO if total==1).
//     byte0[7]=1: frame_abort, abort_code=11, stay IDLE. rx_valid without sof in IDLE: dropped silently.
//   BODY: each rx_valid: update CRC, forward byte, cnt++; on cnt+1==total latch calc_crc, go CRC_LO.
//   CRC_LO: rx_valid: rx_crc[7:0] := byte, update CRC; CRC_HI. CRC_HI: rx_valid: rx_crc[15:8] := byte,
//     update CRC; next cycle frame_done + (crc_ok if residue 0 else crc_err); IDLE.
//   Latency: pay_valid 1 cycle after rx_valid; frame_done 1 cycle after CRC_HI byte. CRC bytes never forwarded.
//   Timeout: busy & ~rx_valid increments idle counter, reset by any rx_valid; reaching TIMEOUT_CYC ->
//     frame_abort, code 01, IDLE, CRC reg 0xFFFF.
//   sof&rx_valid while busy: frame_abort, code 10, same cycle byte treated as new byte0 (IDLE rules).
//   Sof on the CRC_HI byte: restart takes priority; no frame_done for the old frame.
//   err_cnt: +1 per crc_err or frame_abort, saturates at 0xFF; err_clr wins over simultaneous increment.
//   CRC: 8-bit parallel update per byte, one byte per cycle at full rate; back-to-back rx_valid supported.
//   reset_n low mid-frame: immediate return to reset values; no pulses issued.
// TESTING
//   LEN_OFFSET=1; sof+0x00, 0xBF, 0x40 -> pay 0x00; calc_crc=0x40BF, rx_crc=0x40BF, frame_done+crc_ok.
//   LEN_OFFSET=1; sof+0x00, 0xBE, 0x40 -> crc_err pulse, rx_crc=0x40BE, err_cnt 0->1.
//   Default; sof+0x01 then 6 bytes + model CRC, back-to-back -> 6 pay_valid (0x01..), crc_ok, busy low after.
//   Default; frame stalls 1000 cycles after byte 3 -> frame_abort, abort_code=01, busy 0, next frame passes.
//   Mid-frame sof+0x02 -> abort_code=10, new frame of 7 pre-CRC bytes checked correctly; sof+0x80 -> code 11.
//   256 aborts -> err_cnt holds 0xFF; err_clr with simultaneous abort -> err_cnt 0; reset_n mid-frame -> all 0.

Source files
------------

// File: rtl/crc16_frame_checker.sv
// Receive-side CRC-16 (0xA001 reflected, init 0xFFFF) checker for bq79606 UART response frames.
// Tracks frame length from byte 0, forwards pre-CRC bytes, checks the zero residue over the whole
// frame including its trailing CRC, and drops frames on timeout, restart or a bad frame type.
module crc16_frame_checker #(
  parameter int LEN_OFFSET  = 5,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic        sclk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        sof,
  input  logic        err_clr,
  output logic [7:0]  pay_data,
  output logic        pay_valid,
  output logic        frame_done,
  output logic        crc_ok,
  output logic        crc_err,
  output logic [15:0] calc_crc,
  output logic [15:0] rx_crc,
  output logic        frame_abort,
  output logic [1:0]  abort_code,
  output logic [7:0]  err_cnt,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BODY, CRC_LO, CRC_HI} state_t;

  localparam logic [15:0] CRC_INIT     = 16'hFFFF;
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

  // One-byte parallel CRC update, reflected polynomial, data consumed LSB first
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  total_q, total_d;
  logic [15:0] idle_q, idle_d;

  logic [15:0] crc_first;
  logic [15:0] crc_upd;
  logic [7:0]  total_new;
  logic        fwd, start, latch_calc, ld_lo, ld_hi, done, abort;
  logic [1:0]  code;
  logic        err_evt;

  assign crc_first = crc16_byte(CRC_INIT, rx_data);
  assign crc_upd   = crc16_byte(crc_q, rx_data);
  assign total_new = {1'b0, rx_data[6:0]} + 8'(LEN_OFFSET);
  assign busy      = (state_q != IDLE);
  assign err_evt   = abort | (done & (crc_upd != 16'h0000));

  // Next-state and per-cycle control: restart has priority over every in-frame action
  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    total_d    = total_q;
    idle_d     = idle_q;
    fwd        = 1'b0;
    start      = 1'b0;
    latch_calc = 1'b0;
    ld_lo      = 1'b0;
    ld_hi      = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    code       = 2'b00;
    if (rx_valid && sof) begin
      idle_d = '0;
      if (state_q != IDLE) begin
        abort = 1'b1;
        code  = 2'b10;
      end
      if (rx_data[7]) begin
        abort   = 1'b1;
        code    = 2'b11;
        state_d = IDLE;
        crc_d   = CRC_INIT;
        cnt_d   = '0;
      end else begin
        start   = 1'b1;
        fwd     = 1'b1;
        crc_d   = crc_first;
        total_d = total_new;
        cnt_d   = 8'd1;
        if (total_new == 8'd1) begin
          latch_calc = 1'b1;
          state_d    = CRC_LO;
        end else begin
          state_d = BODY;
        end
      end
    end else if (rx_valid) begin
      idle_d = '0;
      case (state_q)
        BODY: begin
          crc_d = crc_upd;
          fwd   = 1'b1;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == total_q) begin
            latch_calc = 1'b1;
            state_d    = CRC_LO;
          end
        end
        CRC_LO: begin
          crc_d   = crc_upd;
          ld_lo   = 1'b1;
          state_d = CRC_HI;
        end
        CRC_HI: begin
          ld_hi   = 1'b1;
          done    = 1'b1;
          state_d = IDLE;
          crc_d   = CRC_INIT;
          cnt_d   = '0;
        end
        default: ;
      endcase
    end else if (state_q != IDLE) begin
      if (idle_q == TIMEOUT_LAST) begin
        abort   = 1'b1;
        code    = 2'b01;
        state_d = IDLE;
        crc_d   = CRC_INIT;
        cnt_d   = '0;
        idle_d  = '0;
      end else begin
        idle_d = idle_q + 16'd1;
      end
    end
  end

  // FSM state and frame-tracking registers
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      crc_q   <= CRC_INIT;
      cnt_q   <= '0;
      total_q <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
      idle_q  <= idle_d;
    end
  end

  // Registered outputs: payload forward, result pulses, latched CRC values and abort status
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      pay_data    <= '0;
      pay_valid   <= 1'b0;
      frame_done  <= 1'b0;
      crc_ok      <= 1'b0;
      crc_err     <= 1'b0;
      calc_crc    <= '0;
      rx_crc      <= '0;
      frame_abort <= 1'b0;
      abort_code  <= '0;
    end else begin
      pay_valid   <= fwd;
      frame_done  <= done;
      crc_ok      <= done & (crc_upd == 16'h0000);
      crc_err     <= done & (crc_upd != 16'h0000);
      frame_abort <= abort;
      if (fwd) pay_data <= rx_data;
      if (abort) abort_code <= code;
      if (start) calc_crc <= latch_calc ? crc_d : 16'h0000;
      else if (latch_calc) calc_crc <= crc_d;
      if (start) rx_crc <= 16'h0000;
      else if (ld_lo) rx_crc[7:0] <= rx_data;
      else if (ld_hi) rx_crc[15:8] <= rx_data;
    end
  end

  // Saturating error counter; a clear request beats a same-cycle error event
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (err_evt && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule
